// File: rtl/ffn_mm_sequencer_pkg.sv
// Shared definitions for the FFN matrix-multiply sequencer.
//   - network parameter defaults (buffer count, frame depth, neuron count, widths)
//   - sequencer state encoding
//   - helper for the neuron index width
package ffn_mm_sequencer_pkg;

    localparam int FFN_NUM_BUF     = 2;
    localparam int FFN_DEPTH       = 256;
    localparam int FFN_ADDR_W      = 8;
    localparam int FFN_NUM_NEURONS = 16;
    localparam int FFN_W_ADDR_W    = 12;
    localparam int FFN_OUT_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_CAPTURE,
        ST_OUT
    } seq_state_t;

    // A single-neuron network still needs a 1-bit index port.
    function automatic int neuron_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ffn_mm_sequencer_if.sv
// Downstream result handshake of the FFN sequencer.
//   out_valid  : out_data/out_neuron hold a finished dot product
//   out_ready  : downstream accepts the result this cycle
//   out_data   : captured MAC sum
//   out_neuron : neuron index the result belongs to
// master = sequencer side, slave = consumer side.
interface ffn_mm_sequencer_if #(
    parameter int OUT_W    = 32,
    parameter int NEURON_W = 4
);
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic [NEURON_W-1:0] out_neuron;

    modport master (output out_valid, output out_data, output out_neuron, input out_ready);
    modport slave  (input out_valid, input out_data, input out_neuron, output out_ready);
endinterface

// File: rtl/ffn_mm_sequencer_addr_gen.sv
// Index/neuron counters and read-address generation for the FFN sequencer.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   clear         : return all counters to zero (frame start / frame end)
//   step          : advance the element index by one (RUN cycle)
//   next_neuron   : move to the next weight row, index back to 0
//   index, neuron : current element and neuron counters
//   w_addr        : weight address, neuron*DEPTH + index
//   last_idx      : index == DEPTH-1
//   last_neuron   : neuron == NUM_NEURONS-1
module ffn_mm_sequencer_addr_gen #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int NUM_NEURONS = 16,
    parameter int W_ADDR_W    = 12,
    parameter int NEURON_W    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                step,
    input  logic                next_neuron,
    output logic [ADDR_W-1:0]   index,
    output logic [NEURON_W-1:0] neuron,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic                last_idx,
    output logic                last_neuron
);
    localparam logic [ADDR_W-1:0]   LAST_IDX    = ADDR_W'(DEPTH - 1);
    localparam logic [NEURON_W-1:0] LAST_NEURON = NEURON_W'(NUM_NEURONS - 1);
    localparam logic [W_ADDR_W-1:0] ROW_STRIDE  = W_ADDR_W'(DEPTH);

    // Start of the current weight row; advanced by DEPTH per neuron so no
    // multiplier is needed.
    logic [W_ADDR_W-1:0] w_base;

    assign last_idx    = (index == LAST_IDX);
    assign last_neuron = (neuron == LAST_NEURON);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            index  <= '0;
            neuron <= '0;
            w_base <= '0;
            w_addr <= '0;
        end else if (step) begin
            // Wrap back to the row start after the last element so the
            // addresses sit at a quiet value outside the burst.
            if (last_idx) begin
                index  <= '0;
                w_addr <= w_base;
            end else begin
                index  <= index + 1'b1;
                w_addr <= w_addr + 1'b1;
            end
        end else if (next_neuron) begin
            neuron <= neuron + 1'b1;
            w_base <= w_base + ROW_STRIDE;
            w_addr <= w_base + ROW_STRIDE;
        end
    end
endmodule

// File: rtl/ffn_mm_sequencer.sv
// FFN matrix-multiply sequencer: owns feature-frame buffers in rotation,
// issues feature/weight read addresses, gates the MAC and hands each
// finished dot product downstream.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   frame_rdy      : per-buffer "frame complete" level from the writer
//   reading_frame  : one-hot buffer currently owned by this block
//   frame_done     : one-cycle release pulse of the owned buffer
//   buf_addr       : feature buffer read address (1-cycle memory)
//   w_addr         : weight read address (1-cycle memory)
//   mac_en         : MAC accumulate enable; low loads the MAC with 0
//   acc_sum        : registered MAC sum
//   out_if         : result handshake (valid/ready/data/neuron)
//
// state    | meaning
// IDLE     | waiting for the selected buffer to be ready
// RUN      | issuing element index 0..DEPTH-1 of the current neuron
// DRAIN    | last read data returning to the MAC
// CAPTURE  | MAC sum complete, latched at the end of this cycle
// OUT      | result presented until out_ready
module ffn_mm_sequencer
    import ffn_mm_sequencer_pkg::*;
#(
    parameter int NUM_BUF     = FFN_NUM_BUF,
    parameter int DEPTH       = FFN_DEPTH,
    parameter int ADDR_W      = FFN_ADDR_W,
    parameter int NUM_NEURONS = FFN_NUM_NEURONS,
    parameter int W_ADDR_W    = FFN_W_ADDR_W,
    parameter int OUT_W       = FFN_OUT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_BUF-1:0]  frame_rdy,
    output logic [NUM_BUF-1:0]  reading_frame,
    output logic [NUM_BUF-1:0]  frame_done,
    output logic [ADDR_W-1:0]   buf_addr,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic                mac_en,
    input  logic [OUT_W-1:0]    acc_sum,
    ffn_mm_sequencer_if.master  out_if
);
    localparam int NEURON_W = neuron_width(NUM_NEURONS);

    seq_state_t          state;
    logic                out_valid_q;
    logic [OUT_W-1:0]    out_data_q;
    logic [NEURON_W-1:0] out_neuron_q;

    logic                clear;
    logic                step;
    logic                next_neuron;
    logic                handshake;
    logic [NEURON_W-1:0] neuron;
    logic                last_idx;
    logic                last_neuron;

    assign handshake   = (state == ST_OUT) && out_if.out_ready;
    assign clear       = (state == ST_IDLE) || (handshake && last_neuron);
    assign step        = (state == ST_RUN);
    assign next_neuron = handshake && !last_neuron;

    ffn_mm_sequencer_addr_gen #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .NUM_NEURONS (NUM_NEURONS),
        .W_ADDR_W    (W_ADDR_W),
        .NEURON_W    (NEURON_W)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .step        (step),
        .next_neuron (next_neuron),
        .index       (buf_addr),
        .neuron      (neuron),
        .w_addr      (w_addr),
        .last_idx    (last_idx),
        .last_neuron (last_neuron)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            reading_frame <= NUM_BUF'(1);
            frame_done    <= '0;
            mac_en        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_neuron_q  <= '0;
        end else begin
            // Delayed by one cycle to line up with the 1-cycle read latency.
            mac_en     <= (state == ST_RUN);
            frame_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|(frame_rdy & reading_frame)) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (last_idx) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    out_data_q   <= acc_sum;
                    out_neuron_q <= neuron;
                    out_valid_q  <= 1'b1;
                    state        <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_neuron) begin
                            frame_done    <= reading_frame;
                            reading_frame <= {reading_frame[NUM_BUF-2:0],
                                              reading_frame[NUM_BUF-1]};
                            state         <= ST_IDLE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_if.out_valid  = out_valid_q;
    assign out_if.out_data   = out_data_q;
    assign out_if.out_neuron = out_neuron_q;
endmodule

// File: doc/ffn_mm_sequencer.md
# ffn_mm_sequencer

Control stage directly upstream of the FFN multiply-accumulate unit (`np_matrix_mult`). It takes ownership of filled feature-frame buffers in rotation. For each output neuron it issues feature and weight read addresses and drives the MAC enable. It captures each finished dot product from the MAC sum and presents it downstream through a valid/ready handshake. The per-neuron burst counter, buffer-select rotation and data-valid logic live here, so the MAC stays a pure datapath.

## Interface
Parameters:
- `NUM_BUF`, default 2: number of feature-frame buffers; must be ≥2.
- `DEPTH`, default 256: dot-product length, i.e. pixels per frame; must be ≥1.
- `ADDR_W`, default 8: feature buffer address width; 2^ADDR_W ≥ DEPTH.
- `NUM_NEURONS`, default 16: dot products per frame, one per weight row.
- `W_ADDR_W`, default 12: weight address width; 2^W_ADDR_W ≥ NUM_NEURONS·DEPTH.
- `OUT_W`, default 32: MAC sum width.

Ports (clock and reset first):
- `clock`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `frame_rdy`, in, NUM_BUF: level; bit i high means buffer i holds a complete frame.
- `reading_frame`, out, NUM_BUF: one-hot selection of the buffer being read.
- `frame_done`, out, NUM_BUF: one-cycle pulse releasing the selected buffer back to the writer.
- `buf_addr`, out, ADDR_W: feature buffer read address; memory latency is 1 cycle.
- `w_addr`, out, W_ADDR_W: weight read address, equal to neuron·DEPTH + index; memory latency is 1 cycle.
- `mac_en`, out, 1: MAC enable; while low, the MAC register is loaded with 0.
- `acc_sum`, in, OUT_W: the MAC's registered sum.
- `out_valid`, out, 1: `out_data` holds a finished dot product.
- `out_ready`, in, 1: the downstream stage accepts the output.
- `out_data`, out, OUT_W: captured dot product.
- `out_neuron`, out, clog2(NUM_NEURONS): index of the neuron `out_data` belongs to.

## Operation
- The FSM has five states: IDLE, RUN, DRAIN, CAPTURE and OUT.
- **IDLE:** wait until `frame_rdy` & `reading_frame` is non-zero, then set neuron to 0 and index to 0 and go to RUN. `frame_rdy` bits of unselected buffers are ignored.
- **RUN:** each cycle, drive `buf_addr` = index and `w_addr` = neuron·DEPTH + index. When index reaches DEPTH-1, go to DRAIN.
- **DRAIN:** one cycle. It covers the read latency for the last element.
- **CAPTURE:** one cycle. At the end of this cycle, latch `out_data` = `acc_sum` and `out_neuron` = neuron.
- **OUT:** hold `out_valid` = 1 until a cycle in which `out_ready` = 1 is sampled.
  - On that handshake, if neuron < NUM_NEURONS-1: increment neuron, clear index, go to RUN.
  - Otherwise: pulse the `frame_done` bit of the selected buffer on the cycle after the handshake, rotate `reading_frame` left by one (wrapping at the top bit), and go to IDLE.
- **`mac_en`:** a one-cycle-delayed copy of "state == RUN", so it is high exactly for DEPTH cycles aligned with the returning read data.
- **Accumulator clear:** `mac_en` is low during CAPTURE and OUT, which zeroes the MAC before the next burst. No separate clear signal exists.
- **Widths and overflow:** no arithmetic is performed here. `out_data` is `acc_sum` bit-for-bit, and MAC overflow is not handled.
- **Reset values:** `reading_frame` = 1 (buffer 0), FSM in IDLE, all counters 0, and `frame_done`, `buf_addr`, `w_addr`, `mac_en`, `out_valid`, `out_data` and `out_neuron` all 0.
- **Reset mid-operation:** return to the reset state on the next edge. No `frame_done` pulse is issued, and the captured output is discarded.

## Timing
- RUN starts in cycle c0 and issues index k in cycle c0+k.
- `mac_en` is high in cycles c0+1 through c0+DEPTH.
- `acc_sum` is complete during CAPTURE at cycle c0+DEPTH+1, and `out_valid` rises at c0+DEPTH+2.
- With `out_ready` held at 1, one neuron takes DEPTH+3 cycles. A full frame takes NUM_NEURONS·(DEPTH+3) cycles plus one IDLE-entry cycle.
- DEPTH = 1: RUN lasts a single cycle; all other timing is unchanged.
- A stall with `out_ready` = 0 only extends OUT. `mac_en` stays low and `out_data` stays stable throughout.
- `frame_done` and a new `frame_rdy` in the same cycle: the new `frame_rdy` belongs to another buffer and is picked up in IDLE after rotation.
- If the next buffer is already ready, RUN begins the cycle after IDLE is entered.

## Structure
- `NUM_BUF`, `DEPTH`, `NUM_NEURONS` and `OUT_W` defaults belong in the shared network parameters header. The state encoding belongs in a shared `ffn_pkg`.
- One sub-module, `ffn_addr_gen`, holds the index/neuron counters and the `w_addr` computation (multiply-free running offset). The top level holds the FSM, `mac_en` delay, capture register and buffer rotation.

## Test plan
- Bench configuration for these scenarios: DEPTH=4 and NUM_NEURONS=2.
- **Basic burst:** a MAC model sums feature·weight; feature = 1,2,3,4 and weight row 0 = 1,1,1,1; `frame_rdy` = 01 with `out_ready` = 1. Required: `out_data` = 10, `out_neuron` = 0, `out_valid` rising 6 cycles after RUN entry, and `mac_en` high for exactly 4 cycles.
- **Second neuron:** weight row 1 = 2,0,0,1. Required: `out_data` = 6, `out_neuron` = 1, and `w_addr` stepping through 4..7.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles. Required: `out_valid` and `out_data` stay stable, `mac_en` stays low, and the next RUN starts the cycle after the handshake.
- **Rotation:** `frame_rdy` = 11. Required: after frame 0, `frame_done` = 01 pulses for one cycle, `reading_frame` becomes 10, and frame 1 is processed. After frame 1, `frame_done` = 10 pulses and `reading_frame` becomes 01.
- **Ignored buffer:** `frame_rdy` = 10 while `reading_frame` = 01. Required: the block stays in IDLE, with `buf_addr` and `mac_en` remaining 0.
- **Reset mid-RUN:** assert `reset` at index 2. Required: all outputs return to their reset values on the next edge, `reading_frame` = 01, and no `frame_done` pulse appears.
